// File: rtl/core_host_seq.sv
// Host-side sequencer: loads data memory from a byte stream, holds then releases
// the core, times its run until Done (or timeout), and drains a result window.
module core_host_seq #(
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_LEN  = 64,
    parameter int unsigned RES_BASE  = 64,
    parameter int unsigned RES_LEN   = 32,
    parameter int unsigned RST_CYC   = 2,
    parameter int unsigned TIMEOUT   = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    output logic        busy,
    output logic        finished,
    output logic        timeout_err,
    output logic [15:0] cycles,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        core_rst,
    input  logic        core_done,
    output logic        mem_own,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] ridx_q, ridx_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] cycles_q, cycles_d;
    logic        terr_q, terr_d;
    logic [16:0] cyc_inc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ridx_q    <= '0;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ridx_q    <= ridx_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            terr_q    <= terr_d;
        end
    end

    // 17-bit increment so the TIMEOUT compare cannot alias on 16-bit wrap
    assign cyc_inc = {1'b0, cycles_q} + 17'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ridx_d    = ridx_q;
        rst_cnt_d = '0;
        cycles_d  = cycles_q;
        terr_d    = terr_q;
        busy      = 1'b0;
        finished  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        core_rst  = 1'b1;
        mem_own   = 1'b1;
        mem_addr  = '0;
        mem_rd_en = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                finished = (state_q == S_DONE);
                if (start) begin
                    idx_d    = '0;
                    cycles_d = '0;
                    terr_d   = 1'b0;
                    state_d  = (LOAD_LEN == 0) ? S_RST : S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                mem_addr = 8'(LOAD_BASE) + idx_q[7:0];
                if (in_valid) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == 16'(LOAD_LEN - 1)) state_d = S_RST;
                end
            end
            S_RST: begin
                busy = 1'b1;
                if (rst_cnt_q == 16'(RST_CYC - 1)) state_d = S_RUN;
                else rst_cnt_d = rst_cnt_q + 16'd1;
            end
            S_RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                mem_own  = 1'b0;
                cycles_d = cyc_inc[15:0];
                ridx_d   = '0;
                if (core_done) begin
                    state_d = (RES_LEN == 0) ? S_DONE : S_DRAIN;
                end else if (cyc_inc == 17'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    state_d = (RES_LEN == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = 8'(RES_BASE) + ridx_q[7:0];
                out_data  = mem_rdata;
                if (out_ready) begin
                    ridx_d = ridx_q + 16'd1;
                    if (ridx_q == 16'(RES_LEN - 1)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_wr_en   = in_valid & in_ready;
    assign mem_wdata   = in_data;
    assign cycles      = cycles_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/core_host_seq.md
Name: core_host_seq

Overview:
Host-side sequencer for the 9-bit-ISA core and its data memory. It takes an input byte stream and loads it into data memory, holds the core in reset, then releases it and times the run until the core raises Done. It then streams a result window of data memory back out. It sits beside the core top level; its memory port is muxed onto the data-memory port whenever mem_own=1.

Parameters:
LOAD_BASE, 0, first data-memory address written during load
LOAD_LEN, 64, bytes accepted on the input stream (0 = skip load)
RES_BASE, 64, first data-memory address read during drain
RES_LEN, 32, bytes emitted on the output stream (0 = skip drain)
RST_CYC, 2, cycles core_rst is held after load, before run (>=1)
TIMEOUT, 16'hFFFF, maximum run cycles before abort (1..65535)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
start  in  1  begin a sequence; sampled in IDLE or DONE only
busy  out  1  high in LOAD/RST/RUN/DRAIN
finished  out  1  high in DONE, held until next start
timeout_err  out  1  set when run aborted by TIMEOUT; cleared on start
cycles  out  16  run-cycle count of the last/current run
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  high in LOAD
out_valid  out  1  high in DRAIN
out_data  out  8  = mem_rdata while in DRAIN
out_ready  in  1  consumer accepts out_data
core_rst  out  1  reset to core; low only in RUN
core_done  in  1  core Done flag
mem_own  out  1  sequencer owns data memory (all states except RUN)
mem_addr  out  8  data-memory address
mem_wdata  out  8  = in_data
mem_wr_en  out  1  = in_valid & in_ready
mem_rd_en  out  1  high in DRAIN
mem_rdata  in  8  combinational read data for mem_addr

Behaviour:
- States: IDLE, LOAD, RST, RUN, DRAIN, DONE. Reset (any time, including mid-sequence) -> IDLE.
- Reset values: busy=0, finished=0, timeout_err=0, cycles=0, in_ready=0, out_valid=0, core_rst=1, mem_own=1, mem_wr_en=0, mem_rd_en=0, mem_addr=0.
- IDLE/DONE: start=1 -> LOAD (or RST if LOAD_LEN=0). The load index, cycles and timeout_err clear on that edge. start is ignored in every other state.
- LOAD: mem_addr=LOAD_BASE+idx (8-bit wrap). A write happens in the same cycle as each handshake. idx increments per handshake. When handshake index LOAD_LEN-1 is accepted -> RST.
- RST: core_rst=1 for exactly RST_CYC cycles -> RUN.
- RUN: core_rst=0, mem_own=0, all mem_* enables=0. cycles increments every RUN cycle, so the first RUN cycle shows cycles=1 on exit.
  - core_done=1 -> DRAIN; core_rst returns to 1 on the next cycle.
  - Otherwise, if cycles+1==TIMEOUT: timeout_err<=1 -> DRAIN.
  - core_done takes priority over timeout on the same cycle.
  - core_done is ignored outside RUN.
- DRAIN: mem_addr=RES_BASE+ridx and out_data=mem_rdata, with zero latency. ridx advances on out_valid&out_ready. After handshake index RES_LEN-1 -> DONE. RES_LEN=0 goes straight to DONE.
- out_data/out_valid stay stable while out_ready=0.
- cycles holds its value after RUN until the next start.

Test Plan:
- LOAD_LEN=4, RES_LEN=2; feed 0x11,0x22,0x33,0x44 with gaps on in_valid -> writes to addr 0..3 only on handshake cycles; RST for 2 cycles; core_rst falls after that.
- Core model raises core_done 10 cycles after release -> cycles=10, timeout_err=0, mem_own=1 next cycle. Drain reads addr 64,65, returning memory values; finished=1.
- TIMEOUT=20, core_done never rises -> leaves RUN with cycles=20, timeout_err=1, drain still performed, finished=1.
- out_ready toggling 1,0,0,1 during drain -> out_data/mem_addr held while stalled; exactly RES_LEN bytes emitted, no duplicates.
- Reset asserted mid-LOAD (after 2 bytes) and mid-RUN -> state IDLE, core_rst=1, in_ready=0, cycles=0 immediately (asynchronous).
- start pulsed during RUN is ignored. Second start in DONE -> timeout_err and cycles clear, new LOAD at idx 0. LOAD_BASE=254, LOAD_LEN=4 -> addresses 254,255,0,1.
